// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU bus types and memory arbiter constants
package cpu_types_pkg;

  // 32-bit bus word used for addresses and data
  typedef logic [31:0] word_t;

  // Memory arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Value returned to the requester when the RAM never acknowledges
  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

  // Default number of BUSY cycles tolerated before an access is aborted
  localparam int ARB_TIMEOUT = 64;

  // Width of the timeout counter; must hold ARB_TIMEOUT-1
  localparam int ARB_CTR_W = 7;

  // True while a RAM access is outstanding
  function automatic logic arb_busy(arb_state_t s);
    return (s == IBUSY) || (s == DBUSY);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - saturating BUSY-cycle counter flagging a stuck RAM access
module arb_timeout_ctr #(
  parameter int W       = 7,
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  logic [W-1:0] cnt_q;

  // Count enabled cycles, hold at the top value, restart whenever cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Expiry is only meaningful while the access is being timed
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data ports
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = ARB_TIMEOUT,
  parameter word_t ERR_WORD = ARB_ERR_WORD
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  ihit,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dhit,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load,
  input  logic  ram_ack,
  output logic  err
);

  arb_state_t state_q;
  logic       last_was_d_q;
  logic       gnt_is_d_q;
  logic       ram_ren_q;
  logic       ram_wen_q;
  word_t      ram_addr_q;
  word_t      ram_store_q;
  word_t      resp_q;
  logic       err_q;

  logic       d_req;
  logic       gnt_d_d;
  logic       gnt_i_d;
  logic       busy;
  logic       expired;

  // Grant choice in IDLE: data first unless it won last time and fetch is waiting
  always_comb begin
    d_req   = dREN | dWEN;
    gnt_d_d = d_req && (!iREN || !last_was_d_q);
    gnt_i_d = iREN && !gnt_d_d;
  end

  assign busy = arb_busy(state_q);

  arb_timeout_ctr #(
    .W       (ARB_CTR_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (!busy),
    .en_i      (busy),
    .expired_o (expired)
  );

  // Arbiter FSM: latch the winning request, hold RAM signals until ack or timeout
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      gnt_is_d_q   <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
      resp_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_d_d) begin
            state_q      <= DBUSY;
            last_was_d_q <= 1'b1;
            gnt_is_d_q   <= 1'b1;
            ram_addr_q   <= daddr;
            ram_store_q  <= dstore;
            // A simultaneous read+write request is serviced as a write
            ram_wen_q    <= dWEN;
            ram_ren_q    <= !dWEN;
          end else if (gnt_i_d) begin
            state_q      <= IBUSY;
            last_was_d_q <= 1'b0;
            gnt_is_d_q   <= 1'b0;
            ram_addr_q   <= iaddr;
            ram_store_q  <= '0;
            ram_wen_q    <= 1'b0;
            ram_ren_q    <= 1'b1;
          end
        end
        IBUSY, DBUSY: begin
          // An ack on the expiry cycle still counts as a normal completion
          if (ram_ack) begin
            resp_q    <= ram_load;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            state_q   <= RESP;
          end else if (expired) begin
            resp_q    <= ERR_WORD;
            err_q     <= 1'b1;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;
  assign err       = err_q;

  // Both ports see the same response word; only the matching hit qualifies it
  assign iload = resp_q;
  assign dload = resp_q;

  // A requester that dropped its request (flush) gets no completion pulse
  assign ihit = (state_q == RESP) && !gnt_is_d_q && iREN;
  assign dhit = (state_q == RESP) &&  gnt_is_d_q && d_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ack;
  logic        err;

  int tests;
  int fails;
  int lat;
  int scnt;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .ihit      (ihit),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dhit      (dhit),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_ack   (ram_ack),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next cycle and update the RAM model: ack in the lat-th strobe cycle
  task automatic tick();
    @(posedge CLK);
    #1;
    if (ram_ren || ram_wen) scnt++;
    else scnt = 0;
    ram_ack  = (lat != 0) && (ram_ren || ram_wen) && (scnt == lat);
    ram_load = ram_addr ^ 32'hA5A50000;
  endtask

  task automatic drop_all();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  typedef struct {
    logic        irn, drn, dwn;
    logic [31:0] ia, da, ds;
    int          lat;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_d;
    logic [31:0] e_load;
  } vec_t;

  vec_t vt[8];

  initial begin
    int hitc;
    int unstable;
    tests = 0; fails = 0; lat = 1; scnt = 0;
    RST = 1'b1; ram_ack = 1'b0; ram_load = '0;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;

    vt[0] = '{1,0,0, 32'h40, 32'h0,   32'h0,        1, 1,0, 32'h40,  32'h0,        0, 32'hA5A50040};
    vt[1] = '{0,1,0, 32'h0,  32'h80,  32'h0,        3, 1,0, 32'h80,  32'h0,        1, 32'hA5A50080};
    vt[2] = '{1,1,0, 32'h44, 32'h84,  32'h0,        2, 1,0, 32'h44,  32'h0,        0, 32'hA5A50044};
    vt[3] = '{1,1,0, 32'h48, 32'h88,  32'h0,        1, 1,0, 32'h88,  32'h0,        1, 32'hA5A50088};
    vt[4] = '{0,0,1, 32'h0,  32'h100, 32'hDEADBEEF, 2, 0,1, 32'h100, 32'hDEADBEEF, 1, 32'hA5A50100};
    vt[5] = '{0,1,1, 32'h0,  32'h104, 32'h12345678, 1, 0,1, 32'h104, 32'h12345678, 1, 32'hA5A50104};
    vt[6] = '{1,0,1, 32'h4C, 32'h108, 32'hCAFEF00D, 1, 1,0, 32'h4C,  32'h0,        0, 32'hA5A5004C};
    vt[7] = '{0,1,0, 32'h0,  32'h8C,  32'h0,        8, 1,0, 32'h8C,  32'h0,        1, 32'hA5A5008C};

    // Reset state
    #3;
    chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
    chk("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_store", ram_store, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // Both ports held, ack latency 1: D at 2, I at 5, D at 8, I at 11
    lat = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
      end
      #1;
      chk($sformatf("alt_c%0d", c), {30'd0, ihit, dhit},
          {30'd0, (c == 5 || c == 11), (c == 2 || c == 8)});
      if (c == 2) chk("alt_dload", dload, 32'hA5A50300);
      if (c == 5) chk("alt_iload", iload, 32'hA5A50200);
    end
    tick(); drop_all(); #1;
    chk("alt_end", {30'd0, ihit, dhit}, 32'd0);

    // Flush: data wins, drops request mid-access; pending fetch granted after RESP
    lat = 2;
    tick(); dREN = 1; daddr = 32'h400; iREN = 1; iaddr = 32'h500; #1;
    tick(); #1;
    chk("fl_c1_addr", ram_addr, 32'h400);
    dREN = 0;
    tick(); #1;
    chk("fl_c2_ren", {31'd0, ram_ren}, 32'd1);
    tick(); #1;
    chk("fl_c3_nohit", {30'd0, ihit, dhit}, 32'd0);
    tick(); #1;
    chk("fl_c4_idle", {31'd0, ram_ren}, 32'd0);
    tick(); #1;
    chk("fl_c5_ren", {31'd0, ram_ren}, 32'd1);
    chk("fl_c5_addr", ram_addr, 32'h500);
    tick(); #1;
    tick(); #1;
    chk("fl_c7_ihit", {30'd0, ihit, dhit}, 32'd2);
    chk("fl_c7_iload", iload, 32'hA5A50500);
    tick(); drop_all(); #1;

    // Table of single accesses
    for (int v = 0; v < 8; v++) begin
      lat = vt[v].lat;
      tick();
      ram_ack = 1'b1;
      iREN = vt[v].irn; dREN = vt[v].drn; dWEN = vt[v].dwn;
      iaddr = vt[v].ia; daddr = vt[v].da; dstore = vt[v].ds;
      #1;
      chk($sformatf("v%0d_c0_idle", v), {29'd0, ram_ren, ram_wen, ihit | dhit}, 32'd0);
      tick(); #1;
      chk($sformatf("v%0d_strobe", v), {30'd0, ram_ren, ram_wen}, {30'd0, vt[v].e_ren, vt[v].e_wen});
      chk($sformatf("v%0d_addr", v), ram_addr, vt[v].e_addr);
      if (vt[v].e_wen) chk($sformatf("v%0d_store", v), ram_store, vt[v].e_store);
      hitc = -1; unstable = 0;
      for (int c = 2; c < 100; c++) begin
        tick();
        iaddr = ~vt[v].ia; daddr = ~vt[v].da; dstore = ~vt[v].ds;
        #1;
        if (ihit || dhit) begin
          hitc = c;
          break;
        end
        if (ram_ren !== vt[v].e_ren || ram_wen !== vt[v].e_wen || ram_addr !== vt[v].e_addr ||
            (vt[v].e_wen && ram_store !== vt[v].e_store)) unstable++;
      end
      chk($sformatf("v%0d_stable", v), 32'(unstable), 32'd0);
      chk($sformatf("v%0d_hit_cycle", v), 32'(hitc), 32'(vt[v].lat + 1));
      chk($sformatf("v%0d_which", v), {30'd0, ihit, dhit}, vt[v].e_d ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_load", v), vt[v].e_d ? dload : iload, vt[v].e_load);
      chk($sformatf("v%0d_err", v), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d_resp_strobe", v), {30'd0, ram_ren, ram_wen}, 32'd0);
      tick(); drop_all(); #1;
      chk($sformatf("v%0d_end", v), {30'd0, ihit, dhit}, 32'd0);
    end

    // Timeout: no ack, 8 BUSY cycles then error response
    lat = 0;
    tick(); dREN = 1; daddr = 32'h600; #1;
    unstable = 0;
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      if (ram_ren !== 1'b1 || dhit !== 1'b0 || err !== 1'b0) unstable++;
    end
    chk("to_busy8", 32'(unstable), 32'd0);
    tick(); #1;
    chk("to_dhit", {30'd0, ihit, dhit}, 32'd1);
    chk("to_dload", dload, 32'hBAD1BAD1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_strobe", {31'd0, ram_ren}, 32'd0);
    tick(); drop_all(); #1;
    chk("to_end", {30'd0, ihit, dhit}, 32'd0);

    // err stays set across a later normal access
    lat = 1;
    tick(); iREN = 1; iaddr = 32'h700; #1;
    tick(); #1;
    tick(); #1;
    chk("es_ihit", {30'd0, ihit, dhit}, 32'd2);
    chk("es_iload", iload, 32'hA5A50700);
    chk("es_err", {31'd0, err}, 32'd1);
    tick(); drop_all(); #1;

    // Reset during IBUSY
    lat = 3;
    tick(); iREN = 1; iaddr = 32'h800; #1;
    tick(); #1;
    chk("rb_c1_ren", {31'd0, ram_ren}, 32'd1);
    tick(); #1;
    #2;
    RST = 1'b1;
    #1;
    chk("rb_ren_drop", {31'd0, ram_ren}, 32'd0);
    chk("rb_addr", ram_addr, 32'd0);
    chk("rb_err", {31'd0, err}, 32'd0);
    iREN = 0;
    unstable = 0;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      if (ihit !== 1'b0 || ram_ren !== 1'b0) unstable++;
    end
    chk("rb_nohit", 32'(unstable), 32'd0);
    RST = 1'b0;
    lat = 1;
    tick(); iREN = 1; iaddr = 32'h900; #1;
    chk("rb2_c0", {30'd0, ram_ren, ihit}, 32'd0);
    tick(); #1;
    chk("rb2_c1_ren", {31'd0, ram_ren}, 32'd1);
    chk("rb2_c1_addr", ram_addr, 32'h900);
    tick(); #1;
    chk("rb2_c2_ihit", {30'd0, ihit, dhit}, 32'd2);
    chk("rb2_c2_iload", iload, 32'hA5A50900);
    tick(); drop_all(); #1;
    chk("rb2_end", {30'd0, ihit, dhit}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
